// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store engine between the MEM pipeline stage and a
// single-port word-addressed data memory. Handles word, halfword and byte
// accesses, performing a read-modify-write for sub-word stores so the memory
// only ever sees full 32-bit writes.
//
// Ports
//   Clk           clock, all state updates on the rising edge
//   reset         asynchronous, active-high reset
//   Req           transaction request, sampled only while idle
//   Op            000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
//   ByteAddr      byte address of the access
//   StoreData     store source (SH uses [15:0], SB uses [7:0])
//   Busy          high whenever a transaction is in flight
//   Done          one-cycle completion pulse
//   LoadData      extended load result, held until the next completed load
//   AddrError     valid with Done: misaligned or out-of-range access
//   MemAddress    word index presented to the memory
//   MemWriteData  write word presented to the memory
//   MemRead       memory read strobe
//   MemWrite      memory write strobe
//   MemReadData   memory read data, registered by the memory on the falling
//                 edge of the MemRead cycle
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [2:0]  Op,
    input  logic [31:0] ByteAddr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] LoadData,
    output logic        AddrError,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemReadData
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } lsuState_t;

    lsuState_t   state;
    lsuState_t   nextState;
    logic        addrErrorNext;
    logic        reqError;
    logic        accept;
    logic [2:0]  opReg;
    logic [1:0]  byteOffset;
    logic [31:0] storeDataReg;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Misalignment for the access width, or a word index past the memory.
    function automatic logic checkAddrError(input logic [2:0] op, input logic [31:0] addr);
        logic misaligned;
        logic outOfRange;
        outOfRange = ({2'b00, addr[31:2]} >= MEM_LIMIT);
        case (op)
            OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            default:              misaligned = 1'b0;
        endcase
        return misaligned | outOfRange;
    endfunction

    // Little-endian lane selection followed by sign or zero extension.
    function automatic logic [31:0] extractLoad(input logic [2:0] op,
                                                input logic [1:0] offset,
                                                input logic [31:0] word);
        logic [15:0] halfVal;
        logic [7:0]  byteVal;
        logic [31:0] result;
        halfVal = offset[1] ? word[31:16] : word[15:0];
        case (offset)
            2'b00:   byteVal = word[7:0];
            2'b01:   byteVal = word[15:8];
            2'b10:   byteVal = word[23:16];
            2'b11:   byteVal = word[31:24];
            default: byteVal = word[7:0];
        endcase
        case (op)
            OP_LW:   result = word;
            OP_LH:   result = {{16{halfVal[15]}}, halfVal};
            OP_LHU:  result = {16'h0000, halfVal};
            OP_LB:   result = {{24{byteVal[7]}}, byteVal};
            OP_LBU:  result = {24'h00_0000, byteVal};
            default: result = word;
        endcase
        return result;
    endfunction

    // Replace only the addressed lane of the word read back from memory.
    function automatic logic [31:0] mergeStore(input logic [2:0] op,
                                               input logic [1:0] offset,
                                               input logic [31:0] word,
                                               input logic [31:0] data);
        logic [31:0] result;
        result = word;
        case (op)
            OP_SH: begin
                if (offset[1]) begin
                    result[31:16] = data[15:0];
                end else begin
                    result[15:0] = data[15:0];
                end
            end
            OP_SB: begin
                case (offset)
                    2'b00:   result[7:0]   = data[7:0];
                    2'b01:   result[15:8]  = data[7:0];
                    2'b10:   result[23:16] = data[7:0];
                    2'b11:   result[31:24] = data[7:0];
                    default: result[7:0]   = data[7:0];
                endcase
            end
            default: result = data;
        endcase
        return result;
    endfunction

    assign reqError = checkAddrError(Op, ByteAddr);
    assign accept   = (state == IDLE) && Req;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------

    // State register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; an errored request goes straight to RESP.
    always_comb begin
        nextState     = state;
        addrErrorNext = 1'b0;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (reqError) begin
                        nextState     = RESP;
                        addrErrorNext = 1'b1;
                    end else begin
                        case (Op)
                            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: nextState = RD;
                            OP_SW:                               nextState = WR;
                            default:                             nextState = RMW_RD;
                        endcase
                    end
                end else begin
                    nextState = IDLE;
                end
            end
            RD:      nextState = RESP;
            RMW_RD:  nextState = WR;
            WR:      nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Status and strobes are registered from the next state, so each is a
    // flop output that tracks the state one-to-one and cannot glitch.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            Busy      <= 1'b0;
            Done      <= 1'b0;
            AddrError <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
        end else begin
            Busy      <= (nextState != IDLE);
            Done      <= (nextState == RESP);
            AddrError <= addrErrorNext;
            MemRead   <= (nextState == RD) || (nextState == RMW_RD);
            MemWrite  <= (nextState == WR);
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------

    // Request capture at accept; MemAddress only moves here, so it stays put
    // from the first strobe through RESP.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            opReg        <= 3'b000;
            byteOffset   <= 2'b00;
            storeDataReg <= 32'h0000_0000;
            MemAddress   <= 32'h0000_0000;
        end else if (accept) begin
            opReg        <= Op;
            byteOffset   <= ByteAddr[1:0];
            storeDataReg <= StoreData;
            MemAddress   <= {2'b00, ByteAddr[31:2]};
        end
    end

    // Write word: full store data for SW at accept, merged lane after the
    // RMW read completes.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            MemWriteData <= 32'h0000_0000;
        end else if (accept && !reqError && (Op == OP_SW)) begin
            MemWriteData <= StoreData;
        end else if (state == RMW_RD) begin
            MemWriteData <= mergeStore(opReg, byteOffset, MemReadData, storeDataReg);
        end
    end

    // Load result only updates at the end of a real read; stores and errored
    // accesses never pass through RD.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            LoadData <= 32'h0000_0000;
        end else if (state == RD) begin
            LoadData <= extractLoad(opReg, byteOffset, MemReadData);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int MEM_WORDS = 32;

    logic        Clk = 1'b0;
    logic        reset;
    logic        Req = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [31:0] ByteAddr = 32'h0;
    logic [31:0] StoreData = 32'h0;
    logic        Busy;
    logic        Done;
    logic [31:0] LoadData;
    logic        AddrError;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemReadData = 32'h0;

    always #5 Clk = ~Clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .Clk(Clk), .reset(reset), .Req(Req), .Op(Op), .ByteAddr(ByteAddr),
        .StoreData(StoreData), .Busy(Busy), .Done(Done), .LoadData(LoadData),
        .AddrError(AddrError), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
    );

    int compared   = 0;
    int mismatched = 0;
    int doneCount  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Attached data memory: read registered on the falling edge of MemRead.
    logic [31:0] mem    [MEM_WORDS];
    logic [31:0] refMem [MEM_WORDS];

    always @(negedge Clk) begin
        if (MemRead) MemReadData <= (MemAddress < MEM_WORDS) ? mem[MemAddress] : 32'hBAD0_BAD0;
    end

    always @(posedge Clk) begin
        if (MemWrite && (MemAddress < MEM_WORDS)) mem[MemAddress] <= MemWriteData;
    end

    // ---------------- reference model (transaction level) ----------------
    function automatic logic isErr(input logic [2:0] op, input logic [31:0] a);
        logic e;
        e = ((a >> 2) >= MEM_WORDS);
        if ((op == 3'd0 || op == 3'd5) && (a % 4 != 0)) e = 1'b1;
        if ((op == 3'd1 || op == 3'd2 || op == 3'd6) && (a % 2 != 0)) e = 1'b1;
        return e;
    endfunction

    function automatic int latOf(input logic [2:0] op, input logic [31:0] a);
        if (isErr(op, a)) return 1;
        if (op >= 3'd6) return 3;
        return 2;
    endfunction

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        if ((a >> 2) < MEM_WORDS) return refMem[a >> 2];
        return 32'h0;
    endfunction

    function automatic logic [31:0] loadResult(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] w);
        int off;
        logic [31:0] b, h;
        off = int'(a % 4);
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            3'd0: return w;
            3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd2: return h;
            3'd3: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4: return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] storeResult(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] sd, input logic [31:0] w);
        int sh;
        logic [31:0] mask;
        case (op)
            3'd5: return sd;
            3'd6: begin
                sh = 16 * int'((a % 4) / 2);
                mask = 32'hFFFF << sh;
                return (w & ~mask) | ((sd & 32'hFFFF) << sh);
            end
            3'd7: begin
                sh = 8 * int'(a % 4);
                mask = 32'hFF << sh;
                return (w & ~mask) | ((sd & 32'hFF) << sh);
            end
            default: return w;
        endcase
    endfunction

    // phase 0 = idle; 1..lat counts cycles since accept, lat being the Done cycle.
    int          phase = 0;
    int          lat = 1;
    logic        mErr = 1'b0;
    logic [2:0]  mOp = 3'b000;
    logic [31:0] expLoad = 32'h0, pendLoad = 32'h0, expAddr = 32'h0, expWdata = 32'h0;

    always @(posedge Clk or posedge reset) begin
        if (reset) begin
            phase   <= 0;
            expLoad <= 32'h0;
        end else if (phase == 0) begin
            if (Req) begin
                mOp      <= Op;
                mErr     <= isErr(Op, ByteAddr);
                lat      <= latOf(Op, ByteAddr);
                expAddr  <= ByteAddr >> 2;
                pendLoad <= loadResult(Op, ByteAddr, wordAt(ByteAddr));
                expWdata <= storeResult(Op, ByteAddr, StoreData, wordAt(ByteAddr));
                phase    <= 1;
            end
        end else begin
            phase <= (phase == lat) ? 0 : phase + 1;
            if ((phase + 1 == lat) && !mErr) begin
                if (mOp <= 3'd4) expLoad <= pendLoad;
                else refMem[expAddr] <= expWdata;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (reset) begin
            chk("rst_busy", Busy, 0);
            chk("rst_done", Done, 0);
            chk("rst_aerr", AddrError, 0);
            chk("rst_mrd", MemRead, 0);
            chk("rst_mwr", MemWrite, 0);
            chk("rst_ldata", LoadData, 0);
            chk("rst_maddr", MemAddress, 0);
            chk("rst_mwdata", MemWriteData, 0);
        end else begin
            chk("busy", Busy, phase != 0);
            chk("done", Done, (phase != 0) && (phase == lat));
            chk("aerr", AddrError, (phase != 0) && (phase == lat) && mErr);
            chk("mrd", MemRead, (phase == 1) && !mErr && (mOp <= 3'd4 || mOp >= 3'd6));
            chk("mwr", MemWrite, !mErr && (((mOp == 3'd5) && (phase == 1)) ||
                                            ((mOp >= 3'd6) && (phase == 2))));
            chk("ldata", LoadData, expLoad);
            if (phase != 0 && !mErr) chk("maddr", MemAddress, expAddr);
            if (MemWrite) chk("mwdata", MemWriteData, expWdata);
            if (Done) doneCount <= doneCount + 1;
        end
        chk("overlap", MemRead & MemWrite, 0);
    end

    // ---------------- stimulus ----------------
    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge Clk);
        while (phase != 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_wait", n < 20, 1);
    endtask

    // Issue one request, return once Done is seen; checks accept->Done latency.
    task automatic doTxn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         input int expLat, input string name);
        int n;
        @(negedge Clk);
        Op = o; ByteAddr = a; StoreData = d; Req = 1'b1;
        n = 0;
        while (phase != 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        @(posedge Clk);
        #1 Req = 1'b0;
        n = 1;
        while (!Done && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk({name, "_lat"}, n, expLat);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
        mem[3] = 32'h8070_F0FF;
        mem[5] = 32'h1122_3344;
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = mem[i];

        reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("reset_busy", Busy, 0);
        chk("reset_ldata", LoadData, 0);
        reset = 1'b0;

        // Loads from word 3
        doTxn(3'd0, 32'h0C, 32'h0, 2, "lw0c");  chk("lw0c", LoadData, 32'h8070_F0FF);
        doTxn(3'd3, 32'h0C, 32'h0, 2, "lb0c");  chk("lb0c", LoadData, 32'hFFFF_FFFF);
        doTxn(3'd4, 32'h0D, 32'h0, 2, "lbu0d"); chk("lbu0d", LoadData, 32'h0000_00F0);
        doTxn(3'd1, 32'h0E, 32'h0, 2, "lh0e");  chk("lh0e", LoadData, 32'hFFFF_8070);
        doTxn(3'd2, 32'h0E, 32'h0, 2, "lhu0e"); chk("lhu0e", LoadData, 32'h0000_8070);
        doTxn(3'd3, 32'h0F, 32'h0, 2, "lb0f");  chk("lb0f", LoadData, 32'hFFFF_FF80);
        doTxn(3'd4, 32'h0E, 32'h0, 2, "lbu0e"); chk("lbu0e", LoadData, 32'h0000_0070);

        // Sub-word stores into word 5 (upper data bits must be ignored)
        doTxn(3'd7, 32'h15, 32'hFFFF_FFAA, 3, "sb15"); chk("sb15_mem", mem[5], 32'h1122_AA44);
        chk("sb_keeps_ldata", LoadData, 32'h0000_0070);
        doTxn(3'd6, 32'h16, 32'h1234_BEEF, 3, "sh16"); chk("sh16_mem", mem[5], 32'hBEEF_AA44);
        doTxn(3'd6, 32'h14, 32'hAAAA_5566, 3, "sh14"); chk("sh14_mem", mem[5], 32'hBEEF_5566);

        // Word store at the last word, then read it back
        doTxn(3'd5, 32'h7C, 32'hDEAD_BEEF, 2, "sw7c"); chk("sw7c_mem", mem[31], 32'hDEAD_BEEF);
        doTxn(3'd0, 32'h7C, 32'h0, 2, "lw7c"); chk("lw7c", LoadData, 32'hDEAD_BEEF);

        // Errored accesses: 1-cycle Done, no strobes, LoadData held
        doTxn(3'd0, 32'h02, 32'h0, 1, "lw02err"); chk("lw02_aerr", AddrError, 1);
        chk("lw02_ldata", LoadData, 32'hDEAD_BEEF);
        doTxn(3'd6, 32'h03, 32'h0000_1111, 1, "sh03err"); chk("sh03_aerr", AddrError, 1);
        doTxn(3'd0, 32'h80, 32'h0, 1, "lw80err"); chk("lw80_ldata", LoadData, 32'hDEAD_BEEF);
        doTxn(3'd3, 32'h81, 32'h0, 1, "lb81err"); chk("lb81_aerr", AddrError, 1);
        chk("sh03_mem", mem[0], 32'h1000_0000);

        // Reset during RMW_RD of an SB
        waitIdle();
        Op = 3'd7; ByteAddr = 32'h15; StoreData = 32'h0000_0077; Req = 1'b1;
        @(posedge Clk);
        #1 Req = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_mrd", MemRead, 0);
        chk("rst_mid_busy", Busy, 0);
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        chk("rst_mid_mem", mem[5], 32'hBEEF_5566);
        d0 = doneCount;
        doTxn(3'd0, 32'h14, 32'h0, 2, "lw14"); chk("lw14", LoadData, 32'hBEEF_5566);

        // Req held high: accept, RD, RESP, one IDLE, repeat
        waitIdle();
        Op = 3'd0; ByteAddr = 32'h0C; StoreData = 32'h0; Req = 1'b1;
        d0 = doneCount;
        repeat (9) @(negedge Clk);
        Req = 1'b0;
        chk("b2b_dones", doneCount - d0, 3);
        waitIdle();
        repeat (2) @(negedge Clk);

        for (int i = 0; i < MEM_WORDS; i++) chk("mem_final", mem[i], refMem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, 32, number of 32-bit words in the attached data memory; valid word indices are 0..MEM_WORDS-1.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Req  input  1  transaction request from MEM stage; sampled only in IDLE.
REQ-005 Op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-006 ByteAddr  input  32  byte address of the access.
REQ-007 StoreData  input  32  store source; SH uses [15:0], SB uses [7:0].
REQ-008 Busy  output  1  high whenever state is not IDLE.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 LoadData  output  32  extended load result, held until the next completed load.
REQ-011 AddrError  output  1  valid with Done; misaligned or out-of-range access.
REQ-012 MemAddress  output  32  word index to the data memory, {2'b00, ByteAddr[31:2]}.
REQ-013 MemWriteData  output  32  write data to the data memory.
REQ-014 MemRead  output  1  memory read strobe.
REQ-015 MemWrite  output  1  memory write strobe.
REQ-016 MemReadData  input  32  memory read data, registered by the memory on the falling edge of the MemRead cycle.

Function
REQ-017 The FSM SHALL use the states IDLE, RD, RMW_RD, WR and RESP.
REQ-018 IDLE with Req=1 SHALL latch Op, ByteAddr and StoreData, check the address, and move on the next edge: error->RESP; LW/LH/LHU/LB/LBU->RD; SW->WR; SH/SB->RMW_RD.
REQ-019 An error SHALL be flagged for LW/SW with ByteAddr[1:0]!=0, for LH/LHU/SH with ByteAddr[0]!=0, or for a word index >=MEM_WORDS; no strobe SHALL assert for an errored access.
REQ-020 RD SHALL assert MemRead for exactly one cycle, capture MemReadData into LoadData at the closing rising edge, and go to RESP.
REQ-021 Load extraction SHALL be little-endian: byte k=ByteAddr[1:0] at bits [8k+7:8k]; halfword at [16*ByteAddr[1]+15 : 16*ByteAddr[1]]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes 32 bits.
REQ-022 RMW_RD SHALL assert MemRead for one cycle, then go to WR with MemWriteData equal to the read word with only the addressed byte or halfword lane replaced by StoreData.
REQ-023 WR SHALL assert MemWrite for exactly one cycle (SW: MemWriteData=StoreData) and then go to RESP.
REQ-024 RESP SHALL pulse Done for one cycle, drive AddrError=1 for an errored access and 0 otherwise, and return to IDLE.
REQ-025 Latency from the accepting edge to Done SHALL be: error 1 cycle; load or SW 2 cycles; SH/SB 3 cycles.
REQ-026 MemRead and MemWrite SHALL never be high in the same cycle, SHALL be decoded from the state only, and SHALL be glitch-free.
REQ-027 MemAddress SHALL be stable from the first strobe through RESP.
REQ-028 Req SHALL be ignored while Busy=1; a Req in the RESP cycle SHALL be dropped, and a new request SHALL be accepted in the IDLE cycle that follows.
REQ-029 LoadData SHALL be unchanged by stores and by errored accesses.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, MemRead=0, MemWrite=0, Busy=0, Done=0, AddrError=0, LoadData=0, MemAddress=0 and MemWriteData=0.
REQ-031 Reset mid-transaction SHALL abort the transaction with no Done; after deassertion a fresh Req SHALL be accepted normally.

Verification
REQ-032 Memory word 3 = 0x8070_F0FF; LB at 0x0C -> LoadData 0xFFFF_FFFF; LBU at 0x0D -> 0x0000_00F0; LH at 0x0E -> 0xFFFF_8070; LHU at 0x0E -> 0x0000_8070; Done 2 cycles after each accept.
REQ-033 Word 5 = 0x1122_3344; SB 0xAA to 0x15 -> word 5 = 0x1122_AA44; SH 0xBEEF to 0x16 -> 0xBEEF_AA44; MemRead 1 cycle, then MemWrite 1 cycle, Done at cycle 3.
REQ-034 SW 0xDEAD_BEEF at 0x7C -> MemAddress=31, one MemWrite, then LW 0x7C -> LoadData 0xDEAD_BEEF.
REQ-035 LW at 0x02, SH at 0x03 and LW at 0x80 (MEM_WORDS=32) -> no strobes, Done+AddrError 1 cycle after accept, LoadData unchanged.
REQ-036 Reset asserted during the RMW_RD cycle of an SB -> strobes drop at once, no Done, memory word unmodified; a following LW completes correctly.
REQ-037 Req held high continuously -> back-to-back transactions with exactly one IDLE cycle between Done and the next strobe; MemRead and MemWrite never overlap.
